tb_multi_rd_memory: RTL

- Parametrised successor to the single-stream testbench read memory.
- One shared storage array feeds NumChannels independent valid/ready read streams.
- Each stream has runtime-configured start/end window, pass count and loop mode, plus per-channel done status and beat counters.
- Drives the IM A/IM B/AM accelerator ports of the Hypercorex testbench top from one instance.

---
 rtl/tb_multi_rd_memory_if.sv | 26 ++
 rtl/tb_multi_rd_memory.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tb_multi_rd_memory_if.sv
// Read-stream bundle for tb_multi_rd_memory: one valid/ready stream per channel,
// packed channel-major (channel c at [c*Width +: Width]).
interface tb_multi_rd_memory_if #(
  parameter int NumChannels = 2,
  parameter int DataWidth   = 512,
  parameter int AddrWidth   = 32
);
  logic [NumChannels*DataWidth-1:0] rd_acc_data_o;
  logic [NumChannels*AddrWidth-1:0] rd_acc_addr_o;
  logic [NumChannels-1:0]           rd_acc_valid_o;
  logic [NumChannels-1:0]           rd_acc_ready_i;

  modport master (
    output rd_acc_data_o,
    output rd_acc_addr_o,
    output rd_acc_valid_o,
    input  rd_acc_ready_i
  );

  modport slave (
    input  rd_acc_data_o,
    input  rd_acc_addr_o,
    input  rd_acc_valid_o,
    output rd_acc_ready_i
  );
endinterface

// File: rtl/tb_multi_rd_memory.sv
// Shared testbench memory feeding NumChannels independent windowed read streams.
// Optional macro TB_MEM_STALL_EN adds per-channel LFSR-driven valid stalls.
module tb_multi_rd_memory #(
  parameter int NumChannels = 2,
  parameter int DataWidth   = 512,
  parameter int AddrWidth   = 32,
  parameter int MemDepth    = 512,
  parameter int PassWidth   = 8,
  parameter int ChanIdWidth = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic [AddrWidth-1:0]        wr_addr_i,
  input  logic [DataWidth-1:0]        wr_data_i,
  input  logic                        wr_en_i,
  input  logic [AddrWidth-1:0]        rd_addr_i,
  output logic [DataWidth-1:0]        rd_data_o,
  input  logic                        cfg_valid_i,
  input  logic [ChanIdWidth-1:0]      cfg_chan_i,
  input  logic [AddrWidth-1:0]        cfg_start_addr_i,
  input  logic [AddrWidth-1:0]        cfg_end_addr_i,
  input  logic [PassWidth-1:0]        cfg_num_pass_i,
  output logic                        cfg_err_o,
  input  logic [NumChannels-1:0]      start_i,
  input  logic [NumChannels-1:0]      stop_i,
  tb_multi_rd_memory_if.master        acc,
  output logic [NumChannels-1:0]      done_o,
  output logic [NumChannels*AddrWidth-1:0] beat_cnt_o
);

  localparam int MemIdxWidth = (MemDepth > 1) ? $clog2(MemDepth) : 1;
  localparam logic [AddrWidth-1:0] MemDepthA = AddrWidth'(MemDepth);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_e;

  function automatic logic [MemIdxWidth-1:0] to_idx(input logic [AddrWidth-1:0] a);
    return a[MemIdxWidth-1:0];
  endfunction

  logic [DataWidth-1:0] mem [MemDepth];

  state_e               state    [NumChannels];
  logic [AddrWidth-1:0] cfg_start[NumChannels];
  logic [AddrWidth-1:0] cfg_end  [NumChannels];
  logic [PassWidth-1:0] cfg_pass [NumChannels];
  logic [AddrWidth-1:0] ptr      [NumChannels];
  logic [AddrWidth-1:0] addr_r   [NumChannels];
  logic [AddrWidth-1:0] beat_cnt [NumChannels];
  logic [PassWidth-1:0] pass_cnt [NumChannels];
  logic [DataWidth-1:0] data_r   [NumChannels];
  logic [NumChannels-1:0] valid_r;
  logic [NumChannels-1:0] done_r;
  logic [NumChannels-1:0] vis;
  logic [NumChannels-1:0] beat;
  logic chan_busy;
  logic cfg_bad;

  // Reads use the pre-edge array contents, so a same-edge write is seen one fetch later.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && (wr_addr_i < MemDepthA)) begin
      mem[to_idx(wr_addr_i)] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (rd_addr_i < MemDepthA) begin
      rd_data_o = mem[to_idx(rd_addr_i)];
    end
  end

  always_comb begin
    chan_busy = 1'b0;
    for (int c = 0; c < NumChannels; c++) begin
      if ((cfg_chan_i == ChanIdWidth'(c)) && (state[c] == STREAM)) begin
        chan_busy = 1'b1;
      end
    end
    cfg_bad = (cfg_start_addr_i > cfg_end_addr_i) ||
              (cfg_end_addr_i >= MemDepthA) ||
              (32'(cfg_chan_i) >= 32'(NumChannels)) ||
              chan_busy;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_err_o <= 1'b0;
      for (int c = 0; c < NumChannels; c++) begin
        cfg_start[c] <= '0;
        cfg_end[c]   <= '0;
        cfg_pass[c]  <= '0;
      end
    end else begin
      cfg_err_o <= cfg_valid_i && cfg_bad;
      for (int c = 0; c < NumChannels; c++) begin
        if (cfg_valid_i && !cfg_bad && (cfg_chan_i == ChanIdWidth'(c))) begin
          cfg_start[c] <= cfg_start_addr_i;
          cfg_end[c]   <= cfg_end_addr_i;
          cfg_pass[c]  <= cfg_num_pass_i;
        end
      end
    end
  end

`ifdef TB_MEM_STALL_EN
  logic [15:0] lfsr [NumChannels];
  logic [NumChannels-1:0] held_r;
  logic [NumChannels-1:0] stall;

  // held_r marks a word already offered, so a stall can never retract it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      held_r <= '0;
      for (int c = 0; c < NumChannels; c++) begin
        lfsr[c] <= 16'hACE1 ^ 16'(c);
      end
    end else if (en_i) begin
      held_r <= vis & ~acc.rd_acc_ready_i & ~stop_i;
      for (int c = 0; c < NumChannels; c++) begin
        lfsr[c] <= {lfsr[c][14:0], lfsr[c][15] ^ lfsr[c][13] ^ lfsr[c][12] ^ lfsr[c][10]};
      end
    end
  end

  always_comb begin
    stall = '0;
    for (int c = 0; c < NumChannels; c++) begin
      stall[c] = lfsr[c][0];
    end
    vis = valid_r & (held_r | ~stall);
  end
`else
  always_comb vis = valid_r;
`endif

  assign beat               = vis & acc.rd_acc_ready_i;
  assign acc.rd_acc_valid_o = vis & {NumChannels{en_i}};
  assign done_o             = done_r;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r <= '0;
      done_r  <= '0;
      for (int c = 0; c < NumChannels; c++) begin
        state[c]    <= IDLE;
        ptr[c]      <= '0;
        addr_r[c]   <= '0;
        beat_cnt[c] <= '0;
        pass_cnt[c] <= '0;
        data_r[c]   <= '0;
      end
    end else if (en_i) begin
      for (int c = 0; c < NumChannels; c++) begin
        unique case (state[c])
          IDLE, DONE: begin
            if (start_i[c] && !stop_i[c]) begin
              state[c]    <= STREAM;
              ptr[c]      <= cfg_start[c];
              addr_r[c]   <= cfg_start[c];
              data_r[c]   <= mem[to_idx(cfg_start[c])];
              pass_cnt[c] <= cfg_pass[c];
              beat_cnt[c] <= '0;
              done_r[c]   <= 1'b0;
              valid_r[c]  <= 1'b1;
            end
          end
          STREAM: begin
            if (beat[c]) begin
              beat_cnt[c] <= beat_cnt[c] + AddrWidth'(1);
            end
            if (stop_i[c]) begin
              state[c]   <= IDLE;
              valid_r[c] <= 1'b0;
            end else if (beat[c]) begin
              if (ptr[c] != cfg_end[c]) begin
                ptr[c]    <= ptr[c] + AddrWidth'(1);
                addr_r[c] <= ptr[c] + AddrWidth'(1);
                data_r[c] <= mem[to_idx(ptr[c] + AddrWidth'(1))];
              end else if ((pass_cnt[c] == '0) || (pass_cnt[c] > PassWidth'(1))) begin
                // A zero pass count means loop forever, so it is never decremented.
                ptr[c]    <= cfg_start[c];
                addr_r[c] <= cfg_start[c];
                data_r[c] <= mem[to_idx(cfg_start[c])];
                if (pass_cnt[c] != '0) begin
                  pass_cnt[c] <= pass_cnt[c] - PassWidth'(1);
                end
              end else begin
                state[c]   <= DONE;
                valid_r[c] <= 1'b0;
                done_r[c]  <= 1'b1;
              end
            end
          end
          default: begin
            state[c]   <= IDLE;
            valid_r[c] <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_pack
    assign acc.rd_acc_data_o[c*DataWidth +: DataWidth] = data_r[c];
    assign acc.rd_acc_addr_o[c*AddrWidth +: AddrWidth] = addr_r[c];
    assign beat_cnt_o[c*AddrWidth +: AddrWidth]        = beat_cnt[c];
  end

endmodule
